hazard_seq_ctrl: RTL

//  Pipeline sequencing controller for the 5-stage RV32I core with static branch prediction.

---
 rtl/hazard_seq_ctrl_if.sv | 52 +++++
 rtl/hazard_seq_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/hazard_seq_ctrl_if.sv
// Hazard/sequencing bus between the core datapath (master) and hazard_seq_ctrl (slave).
// Carries hazard sources in, segment-register controls, PC select and perf state out.
interface hazard_seq_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1_d;
    logic [4:0]       rs2_d;
    logic             rs1_use_d;
    logic             rs2_use_d;
    logic [4:0]       rd_e;
    logic             mem2reg_e;
    logic             is_br_e;
    logic             br_taken_e;
    logic             predict_e;
    logic             jal_d;
    logic             dcache_miss;
    logic             miss_done;
    logic             perf_clr;

    logic             bubbleF;
    logic             bubbleD;
    logic             bubbleE;
    logic             bubbleM;
    logic             bubbleW;
    logic             flushF;
    logic             flushD;
    logic             flushE;
    logic             flushM;
    logic             flushW;
    logic [1:0]       pc_sel;
    logic [CNT_W-1:0] mispred_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             stall_timeout;

    modport master (
        output rs1_d, rs2_d, rs1_use_d, rs2_use_d, rd_e, mem2reg_e,
               is_br_e, br_taken_e, predict_e, jal_d,
               dcache_miss, miss_done, perf_clr,
        input  bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
               flushF, flushD, flushE, flushM, flushW,
               pc_sel, mispred_cnt, stall_cnt, stall_timeout
    );

    modport slave (
        input  rs1_d, rs2_d, rs1_use_d, rs2_use_d, rd_e, mem2reg_e,
               is_br_e, br_taken_e, predict_e, jal_d,
               dcache_miss, miss_done, perf_clr,
        output bubbleF, bubbleD, bubbleE, bubbleM, bubbleW,
               flushF, flushD, flushE, flushM, flushW,
               pc_sel, mispred_cnt, stall_cnt, stall_timeout
    );
endinterface

// File: rtl/hazard_seq_ctrl.sv
// Pipeline sequencing controller: bubble/flush/PC-select from dcache freeze, mispredict, load-use, JAL.
// Controls are combinational (zero latency); counters/watchdog registered; a dcache miss freezes the pipe.
module hazard_seq_ctrl #(
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_seq_ctrl_if.slave    bus
);
    localparam int              WD_W   = $clog2(MAX_STALL + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(MAX_STALL);

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_RUN    = 2'd1,
        S_MSTALL = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_freeze;
    logic             w_mispred;
    logic             w_load_use;
    logic             w_mis_inc;
    logic [4:0]       w_bub;
    logic [4:0]       w_flu;
    logic [1:0]       w_pc_sel;
    logic [WD_W-1:0]  r_wd_cnt;
    logic [WD_W-1:0]  w_wd_nxt;
    logic [CNT_W-1:0] r_mis_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             r_timeout;

    assign w_freeze = ((r_state == S_RUN) && bus.dcache_miss && !bus.miss_done) ||
                      ((r_state == S_MSTALL) && !bus.miss_done);

    assign w_mispred = bus.is_br_e && (bus.br_taken_e != bus.predict_e);

    assign w_load_use = bus.mem2reg_e && (bus.rd_e != 5'd0) &&
                        (((bus.rd_e == bus.rs1_d) && bus.rs1_use_d) ||
                         ((bus.rd_e == bus.rs2_d) && bus.rs2_use_d));

    assign w_mis_inc = (r_state != S_INIT) && !w_freeze && w_mispred;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:   w_state_nxt = S_RUN;
            S_RUN:    if (bus.dcache_miss && !bus.miss_done) w_state_nxt = S_MSTALL;
            S_MSTALL: if (bus.miss_done) w_state_nxt = S_RUN;
            default:  w_state_nxt = S_INIT;
        endcase
    end

    // Bit order F,D,E,M,W from MSB. Mispredict outranks load-use/JAL: those are wrong-path.
    always_comb begin
        w_bub    = 5'b00000;
        w_flu    = 5'b00000;
        w_pc_sel = 2'b00;
        if (r_state == S_INIT) begin
            w_flu = 5'b11111;
        end else if (w_freeze) begin
            w_bub = 5'b11110;
            w_flu = 5'b00001;
        end else if (w_mispred) begin
            w_flu    = 5'b01100;
            w_pc_sel = bus.br_taken_e ? 2'b01 : 2'b10;
        end else if (w_load_use) begin
            w_bub = 5'b11000;
            w_flu = 5'b00100;
        end else if (bus.jal_d) begin
            w_flu    = 5'b01000;
            w_pc_sel = 2'b11;
        end
    end

    assign bus.bubbleF = w_bub[4];
    assign bus.bubbleD = w_bub[3];
    assign bus.bubbleE = w_bub[2];
    assign bus.bubbleM = w_bub[1];
    assign bus.bubbleW = w_bub[0];
    assign bus.flushF  = w_flu[4];
    assign bus.flushD  = w_flu[3];
    assign bus.flushE  = w_flu[2];
    assign bus.flushM  = w_flu[1];
    assign bus.flushW  = w_flu[0];
    assign bus.pc_sel  = w_pc_sel;

    // Watchdog length counts every frozen cycle of one miss episode, including the entry cycle.
    always_comb begin
        w_wd_nxt = '0;
        if (w_freeze) begin
            w_wd_nxt = (r_wd_cnt == WD_MAX) ? r_wd_cnt : r_wd_cnt + WD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt    <= '0;
            r_mis_cnt   <= '0;
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_wd_cnt <= w_wd_nxt;
            if (bus.perf_clr) begin
                r_mis_cnt   <= '0;
                r_stall_cnt <= '0;
                r_timeout   <= 1'b0;
            end else begin
                if (w_mis_inc && (r_mis_cnt != '1)) begin
                    r_mis_cnt <= r_mis_cnt + CNT_W'(1);
                end
                if (w_freeze && (r_stall_cnt != '1)) begin
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                end
                if (w_freeze && (w_wd_nxt == WD_MAX)) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign bus.mispred_cnt   = r_mis_cnt;
    assign bus.stall_cnt     = r_stall_cnt;
    assign bus.stall_timeout = r_timeout;
endmodule
